// File: rtl/audio_rom_arb.sv
// Three-client round-robin arbiter for a shared audio ROM port, with a
// one-word cache per client so repeated fetches of the same word skip memory.
module audio_rom_arb #(
  parameter int AW   = 22,
  parameter int NCLI = 3
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               load_en,
  input  logic [NCLI-1:0]    cli_req,
  input  logic [NCLI*AW-1:0] cli_addr,
  output logic [NCLI-1:0]    cli_ack,
  output logic [NCLI*32-1:0] cli_data,
  output logic               mem_req,
  output logic [AW-1:0]      mem_addr,
  input  logic               mem_ack,
  input  logic [31:0]        mem_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state;
  logic [1:0]      rr_ptr;
  logic [1:0]      grant;
  logic [AW-1:0]   tag [NCLI];
  logic [NCLI-1:0] tag_valid;

  logic [NCLI-1:0] req_live;
  logic            pick_found;
  logic [1:0]      pick;
  logic [2:0]      idx;
  logic [AW-1:0]   pick_addr;
  logic            pick_hit;

  // Round-robin search starting at rr_ptr; a client already being acked is skipped.
  always_comb begin
    req_live   = cli_req & ~cli_ack;
    pick_found = 1'b0;
    pick       = 2'd0;
    idx        = 3'd0;
    for (int i = 0; i < 3; i++) begin
      idx = {1'b0, rr_ptr} + 3'(i);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!pick_found && req_live[idx[1:0]]) begin
        pick_found = 1'b1;
        pick       = idx[1:0];
      end
    end
    pick_addr = cli_addr[pick*AW +: AW];
    pick_hit  = tag_valid[pick] && (tag[pick] == pick_addr);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= 2'd0;
      grant     <= 2'd0;
      tag_valid <= '0;
      cli_ack   <= '0;
      cli_data  <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      for (int i = 0; i < NCLI; i++) tag[i] <= '0;
    end else begin
      cli_ack <= '0;
      mem_req <= 1'b0;
      case (state)
        IDLE: begin
          if (!load_en && pick_found) begin
            grant <= pick;
            if (pick_hit) begin
              cli_ack[pick] <= 1'b1;
              state         <= DONE;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= pick_addr;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (mem_ack) begin
            cli_data[grant*32 +: 32] <= mem_dout;
            tag[grant]               <= mem_addr;
            tag_valid[grant]         <= 1'b1;
            cli_ack[grant]           <= 1'b1;
            state                    <= DONE;
          end
        end
        DONE: begin
          rr_ptr <= (grant == 2'd2) ? 2'd0 : grant + 2'd1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A download invalidates every cache line, including one filled this cycle.
      if (load_en) tag_valid <= '0;
    end
  end

endmodule

// File: tb/tb_audio_rom_arb.sv
// Bench for audio_rom_arb: directed scenarios with literal expectations, then
// random traffic checked every cycle against a timestamp-based reference model.
module tb_audio_rom_arb;
  localparam int AW = 22;

  logic             clk_sys = 1'b0;
  logic             reset   = 1'b0;
  logic             load_en = 1'b0;
  logic [2:0]       cli_req = '0;
  logic [3*AW-1:0]  cli_addr = '0;
  logic [2:0]       cli_ack;
  logic [95:0]      cli_data;
  logic             mem_req;
  logic [AW-1:0]    mem_addr;
  logic             mem_ack = 1'b0;
  logic [31:0]      mem_dout = '0;

  int checks = 0;
  int errors = 0;

  audio_rom_arb #(.AW(AW), .NCLI(3)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .load_en (load_en),
    .cli_req (cli_req),
    .cli_addr(cli_addr),
    .cli_ack (cli_ack),
    .cli_data(cli_data),
    .mem_req (mem_req),
    .mem_addr(mem_addr),
    .mem_ack (mem_ack),
    .mem_dout(mem_dout)
  );

  initial forever #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Reference model: the cache contents plus the cycle numbers at which each
  // output event is due, derived from the latency rules of the arbiter.
  longint          n = 0;
  bit              m_out;
  int              m_g, m_rr;
  longint          m_req_at, m_ack_at, m_wait_from, m_free_at;
  logic [AW-1:0]   m_addr;
  logic [AW-1:0]   m_tag [3];
  bit              m_val [3];
  logic [31:0]     m_data [3];

  initial begin : model
    logic [2:0]  exp_ack;
    logic [2:0]  masked;
    logic [AW-1:0] a;
    int c;
    bit found;
    forever begin
      @(negedge clk_sys);
      n++;
      if (reset) begin
        m_out = 0; m_g = 0; m_rr = 0;
        m_req_at = -1; m_ack_at = -1; m_wait_from = 0; m_free_at = 0;
        m_addr = '0;
        for (int k = 0; k < 3; k++) begin
          m_val[k] = 0; m_tag[k] = '0; m_data[k] = '0;
        end
        checkOutput("reset cli_ack", cli_ack, 0);
        checkOutput("reset mem_req", mem_req, 0);
        checkOutput("reset mem_addr", mem_addr, 0);
        checkOutput("reset cli_data", cli_data, 0);
      end else begin
        exp_ack = (n == m_ack_at) ? 3'(1 << m_g) : 3'b000;
        checkOutput("model cli_ack", cli_ack, exp_ack);
        checkOutput("model mem_req", mem_req, (n == m_req_at));
        checkOutput("model mem_addr", mem_addr, m_addr);
        checkOutput("model cli_data", cli_data, {m_data[2], m_data[1], m_data[0]});
        if (m_out && n >= m_wait_from && mem_ack) begin
          m_data[m_g] = mem_dout;
          m_tag[m_g]  = m_addr;
          m_val[m_g]  = 1;
          m_ack_at    = n + 1;
          m_free_at   = n + 2;
          m_out       = 0;
        end else if (!m_out && n >= m_free_at && !load_en) begin
          masked = cli_req & ~exp_ack;
          found  = 0;
          for (int k = 0; k < 3; k++) begin
            c = (m_rr + k) % 3;
            if (!found && masked[c]) begin
              found = 1;
              m_g   = c;
            end
          end
          if (found) begin
            m_rr = (m_g + 1) % 3;
            a = cli_addr[m_g*AW +: AW];
            if (m_val[m_g] && m_tag[m_g] == a) begin
              m_ack_at  = n + 1;
              m_free_at = n + 2;
            end else begin
              m_req_at    = n + 1;
              m_addr      = a;
              m_wait_from = n + 2;
              m_out       = 1;
            end
          end
        end
        if (load_en) for (int k = 0; k < 3; k++) m_val[k] = 0;
      end
    end
  end

  // Runs cycles, answering any mem_req one cycle later, until some client is acked.
  task automatic runUntilAck(input int maxCycles, input logic [31:0] data,
                             output logic [2:0] ack, output int reqCount);
    logic pend;
    pend = 0; ack = '0; reqCount = 0;
    for (int i = 0; i < maxCycles; i++) begin
      tick();
      mem_ack = 1'b0;
      if (pend) begin
        mem_ack = 1'b1; mem_dout = data; pend = 0;
      end
      if (mem_req) begin
        pend = 1; reqCount++;
      end
      if (cli_ack != 0) begin
        ack = cli_ack;
        break;
      end
    end
    mem_ack = 1'b0;
  endtask

  int mem_cnt  = 0;
  int load_cnt = 0;

  task automatic applyStimulus();
    if (reset) reset = 1'b0;
    else if ($urandom_range(0, 499) == 0) begin
      reset = 1'b1; mem_cnt = 0;
    end
    for (int c = 0; c < 3; c++) begin
      if (cli_req[c]) begin
        if (cli_ack[c]) cli_req[c] = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        cli_addr[c*AW +: AW] = AW'($urandom_range(1, 4) << 4);
        cli_req[c] = 1'b1;
      end
    end
    mem_ack = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_ack = 1'b1; mem_dout = $urandom;
      end
    end else if ($urandom_range(0, 15) == 0) begin
      mem_ack = 1'b1; mem_dout = $urandom;
    end
    if (mem_req) mem_cnt = $urandom_range(1, 5);
    if (load_cnt > 0) load_cnt--;
    else if ($urandom_range(0, 39) == 0) load_cnt = $urandom_range(1, 4);
    load_en = (load_cnt > 0);
  endtask

  initial begin : main
    logic [2:0] ack;
    int rc, reqs, acks;
    #2 reset = 1'b1;
    tick();
    checkOutput("reset state ack", cli_ack, 3'b000);
    checkOutput("reset state data", cli_data, 96'h0);
    tick();
    reset = 1'b0;

    // Miss on client 0, memory answers four cycles after the strobe.
    cli_addr[0 +: AW] = 22'h00010;
    cli_req[0] = 1'b1;
    tick();
    checkOutput("miss mem_req", mem_req, 1'b1);
    checkOutput("miss mem_addr", mem_addr, 22'h00010);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("miss single strobe", mem_req, 1'b0);
      checkOutput("miss no early ack", cli_ack, 3'b000);
    end
    tick();
    mem_ack = 1'b1; mem_dout = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    checkOutput("miss ack", cli_ack, 3'b001);
    checkOutput("miss data", cli_data[31:0], 32'hDEADBEEF);
    checkOutput("miss addr held", mem_addr, 22'h00010);
    cli_req[0] = 1'b0;
    tick();

    // Repeat of the same word hits the cache.
    cli_req[0] = 1'b1;
    tick();
    checkOutput("hit ack", cli_ack, 3'b001);
    checkOutput("hit no mem_req", mem_req, 1'b0);
    cli_req[0] = 1'b0;
    tick();

    // Simultaneous misses from reset are served 0,1,2; the next round starts at 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cli_addr = {22'h00300, 22'h00200, 22'h00100};
    cli_req  = 3'b111;
    runUntilAck(20, 32'h11110000, ack, rc);
    checkOutput("rr first", ack, 3'b001);
    checkOutput("rr first miss", rc, 1);
    cli_req[0] = 1'b0;
    runUntilAck(20, 32'h22220000, ack, rc);
    checkOutput("rr second", ack, 3'b010);
    cli_req[1] = 1'b0;
    runUntilAck(20, 32'h33330000, ack, rc);
    checkOutput("rr third", ack, 3'b100);
    checkOutput("rr data", cli_data, {32'h33330000, 32'h22220000, 32'h11110000});
    cli_req = 3'b111;
    runUntilAck(20, 32'h0, ack, rc);
    checkOutput("rr wrap to 0", ack, 3'b001);
    checkOutput("rr wrap hit", rc, 0);
    cli_req[0] = 1'b0;
    runUntilAck(20, 32'h0, ack, rc);
    cli_req[1] = 1'b0;
    runUntilAck(20, 32'h0, ack, rc);
    checkOutput("rr wrap last", ack, 3'b100);
    cli_req[2] = 1'b0;
    tick();

    // A download between two identical client 1 requests forces a refetch.
    cli_req[1] = 1'b1;
    runUntilAck(20, 32'h0, ack, rc);
    checkOutput("pre-load hit", ack, 3'b010);
    checkOutput("pre-load no fetch", rc, 0);
    cli_req[1] = 1'b0;
    tick();
    load_en = 1'b1;
    tick();
    cli_req[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("load inhibit mem_req", mem_req, 1'b0);
      checkOutput("load inhibit ack", cli_ack, 3'b000);
    end
    load_en = 1'b0;
    runUntilAck(20, 32'h44440000, ack, rc);
    checkOutput("post-load ack", ack, 3'b010);
    checkOutput("post-load refetch", rc, 1);
    checkOutput("post-load addr", mem_addr, 22'h00200);
    cli_req[1] = 1'b0;
    tick();

    // Reset while waiting on memory drops the transaction.
    cli_addr[0 +: AW] = 22'h00400;
    cli_req[0] = 1'b1;
    tick();
    checkOutput("wait-reset issue", mem_req, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("wait-reset ack", cli_ack, 3'b000);
    checkOutput("wait-reset mem_req", mem_req, 1'b0);
    checkOutput("wait-reset data", cli_data, 96'h0);
    cli_req[0] = 1'b0;
    tick();
    reset = 1'b0;
    mem_ack = 1'b1; mem_dout = 32'hBADBAD00;
    tick();
    mem_ack = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      if (cli_ack != 0 || mem_req) acks++;
      tick();
    end
    checkOutput("stray ack ignored", acks, 0);

    // Client 2 waits indefinitely on a withheld mem_ack.
    cli_addr[2*AW +: AW] = 22'h00500;
    cli_req[2] = 1'b1;
    tick();
    checkOutput("idle after reset", mem_req, 1'b1);
    reqs = 1; acks = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (mem_req) reqs++;
      if (cli_ack != 0) acks++;
    end
    checkOutput("long wait strobes", reqs, 1);
    checkOutput("long wait acks", acks, 0);
    mem_ack = 1'b1; mem_dout = 32'h55550000;
    tick();
    mem_ack = 1'b0;
    checkOutput("long wait done", cli_ack, 3'b100);
    checkOutput("long wait data", cli_data[95:64], 32'h55550000);
    cli_req[2] = 1'b0;
    tick();

    repeat (3000) begin
      tick();
      applyStimulus();
    end
    reset = 1'b0; load_en = 1'b0; cli_req = '0; mem_ack = 1'b0;
    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
